// File: rtl/arbitro_saida_serial.sv
// arbitro_saida_serial: round-robin arbiter that shares one serial transmitter among N requesters,
// sequencing start pulse, completion wait with watchdog, and acknowledge.
module arbitro_saida_serial #(
    parameter int N       = 4,
    parameter int W       = 7,
    parameter int TIMEOUT = 4096
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   pedido,
    input  logic [N*W-1:0] dados,
    input  logic           tx_pronto,
    output logic           tx_partida,
    output logic [W-1:0]   tx_dados,
    output logic [N-1:0]   concedido,
    output logic           erro,
    output logic           ocupado,
    output logic [2:0]     db_vez,
    output logic [3:0]     db_estado
);
    localparam int IW  = $clog2(N);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        OCIOSO  = 4'b0000,
        ARBITRA = 4'b0001,
        CARREGA = 4'b0011,
        AGUARDA = 4'b0111,
        CONCLUI = 4'b1111,
        ERRO    = 4'b1110
    } estado_t;

    estado_t        estado, nxt;
    logic [IW-1:0]  ptr, idx, pick, j;
    logic [WDW-1:0] wd;
    logic [W-1:0]   sel;

    // Scan from the farthest offset down so the nearest pending requester to ptr wins.
    always_comb begin
        pick = ptr;
        j    = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (pedido[j]) pick = j;
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++)
            if (pick == IW'(i)) sel = dados[i*W +: W];
    end

    always_comb begin
        case (estado)
            OCIOSO:  nxt = |pedido ? ARBITRA : OCIOSO;
            ARBITRA: nxt = |pedido ? CARREGA : OCIOSO;
            CARREGA: nxt = AGUARDA;
            AGUARDA: nxt = tx_pronto ? CONCLUI : (wd == WDW'(TIMEOUT - 1) ? ERRO : AGUARDA);
            default: nxt = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado     <= OCIOSO;
            ptr        <= '0;
            idx        <= '0;
            wd         <= '0;
            tx_dados   <= '0;
            tx_partida <= 1'b0;
            concedido  <= '0;
            erro       <= 1'b0;
            ocupado    <= 1'b0;
        end else begin
            estado     <= nxt;
            tx_partida <= nxt == CARREGA;
            concedido  <= nxt == CONCLUI ? N'(1) << idx : '0;
            erro       <= nxt == ERRO;
            ocupado    <= nxt != OCIOSO;
            if (estado == ARBITRA && |pedido) begin
                idx      <= pick;
                tx_dados <= sel;
                wd       <= '0;
            end
            if (estado == AGUARDA && nxt == AGUARDA) wd <= wd + 1'b1;
            // Advancing past the served or aborted requester keeps a dead one from starving the rest.
            if (estado == CONCLUI || estado == ERRO) ptr <= idx == IW'(N - 1) ? '0 : idx + 1'b1;
        end
    end

    assign db_vez    = 3'(idx);
    assign db_estado = estado inside {OCIOSO, ARBITRA, CARREGA, AGUARDA, CONCLUI, ERRO} ? estado : 4'b1101;
endmodule

// File: tb/tb_arbitro_saida_serial.sv
// tb_arbitro_saida_serial: randomized and directed transactions against a transaction-level
// round-robin / watchdog reference model.
module tb_arbitro_saida_serial;
    localparam int N  = 4;
    localparam int W  = 7;
    localparam int TO = 8;

    logic           clock = 1'b0, reset = 1'b0, tx_pronto = 1'b0;
    logic [N-1:0]   pedido = '0;
    logic [N*W-1:0] dados = '0;
    logic           tx_partida, erro, ocupado;
    logic [W-1:0]   tx_dados;
    logic [N-1:0]   concedido;
    logic [2:0]     db_vez;
    logic [3:0]     db_estado;

    int         n_cmp = 0, n_err = 0, ptr_m = 0, last_w = 0;
    logic [W-1:0] last_d = '0;
    logic [W-1:0] palavra [N];
    bit         aleatorio = 1'b0;

    arbitro_saida_serial #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .pedido(pedido), .dados(dados), .tx_pronto(tx_pronto),
        .tx_partida(tx_partida), .tx_dados(tx_dados), .concedido(concedido), .erro(erro),
        .ocupado(ocupado), .db_vez(db_vez), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic verif(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic carrega_dados();
        for (int i = 0; i < N; i++) dados[i*W +: W] = palavra[i];
    endtask

    task automatic sorteia();
        for (int i = 0; i < N; i++) palavra[i] = W'($urandom);
        carrega_dados();
    endtask

    // Round-robin rule: first pending requester at ptr, ptr+1, ... (mod N).
    function automatic int rr(input logic [N-1:0] req);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) begin
            r = req >> ((ptr_m + k) % N);
            if (r[0]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    function automatic int sorteia_d();
        int s;
        s = int'($urandom_range(0, 5));
        return s == 0 ? -1 : s == 1 ? 0 : s == 2 ? TO : s == 3 ? TO + 1 : int'($urandom_range(1, TO));
    endfunction

    // Called at a point just after a rising edge with the DUT idle and pedido already set.
    // d: cycles after the start pulse at which tx_pronto pulses (-1 never, 0 during the start cycle).
    task automatic transacao(input int d, input int rst_cyc, input bit chk_rst);
        int w, lat, cyc, np;
        bit ok, got;
        logic [W-1:0] exp_d;
        w = rr(pedido);
        if (w < 0) w = 0;
        exp_d = palavra[w];
        ok = d >= 1 && d <= TO;
        @(negedge clock);
        verif("ocioso_estado", db_estado, 4'b0000);
        verif("ocioso_ocupado", ocupado, 1'b0);
        verif("ocioso_pulsos", {tx_partida, erro, concedido}, 0);
        if (chk_rst) begin
            verif("rst_tx_dados", tx_dados, 0);
            verif("rst_db_vez", db_vez, 0);
        end
        lat = 0;
        while (!tx_partida && lat < 8) begin
            @(negedge clock);
            lat++;
        end
        verif("lat_partida", lat, 2);
        verif("tx_dados", tx_dados, exp_d);
        verif("db_vez", db_vez, w);
        verif("estado_carrega", db_estado, 4'b0011);
        verif("ocupado", ocupado, 1'b1);
        last_d = exp_d;
        last_w = w;
        sorteia();
        if (aleatorio && $urandom_range(0, 3) == 0) pedido[w] = 1'b0;
        tx_pronto = d == 0;
        np = 0;
        got = 1'b0;
        for (cyc = 1; cyc <= TO + 4; cyc++) begin
            @(posedge clock);
            #1;
            if (cyc == rst_cyc + 1) begin
                reset = 1'b1;
                tx_pronto = 1'b0;
                ptr_m = 0;
                last_d = '0;
                last_w = 0;
                return;
            end
            tx_pronto = cyc == d;
            reset = !(cyc == rst_cyc);
            @(negedge clock);
            np += int'(tx_partida);
            if (concedido != 0 || erro) begin
                got = 1'b1;
                break;
            end
        end
        verif("fim_chegou", got, 1'b1);
        verif("lat_fim", cyc, ok ? d + 1 : TO + 1);
        verif("concedido", concedido, ok ? 32'd1 << w : 32'd0);
        verif("erro", erro, !ok);
        verif("partida_unica", np, 0);
        verif("tx_dados_retido", tx_dados, exp_d);
        verif("estado_fim", db_estado, ok ? 4'b1111 : 4'b1110);
        ptr_m = (w + 1) % N;
        @(posedge clock);
        #1;
        tx_pronto = 1'b0;
        if (ok) pedido[w] = 1'b0;
    endtask

    initial begin
        sorteia();
        repeat (3) @(posedge clock);
        @(negedge clock);
        verif("rst_estado", db_estado, 4'b0000);
        verif("rst_pulsos", {tx_partida, erro, concedido, ocupado}, 0);
        verif("rst_dados", tx_dados, 0);
        verif("rst_vez", db_vez, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        palavra[2] = 7'h41;
        carrega_dados();
        pedido = 4'b0100;
        transacao(5, -1, 1'b0);

        pedido = 4'b0101;
        transacao(int'($urandom_range(1, TO)), -1, 1'b0);
        transacao(int'($urandom_range(1, TO)), -1, 1'b0);

        pedido = 4'b0010;
        transacao(-1, -1, 1'b0);
        transacao(TO, -1, 1'b0);

        pedido = 4'b0001;
        transacao(0, -1, 1'b0);
        transacao(TO + 1, -1, 1'b0);
        transacao(3, -1, 1'b0);

        pedido = 4'b1000;
        transacao(-1, 2, 1'b0);
        transacao(4, -1, 1'b1);

        pedido = 4'b1111;
        repeat (4) transacao(int'($urandom_range(1, TO)), -1, 1'b0);

        pedido = 4'b0010;
        @(posedge clock);
        #1;
        pedido = '0;
        @(negedge clock);
        verif("arbitra", db_estado, 4'b0001);
        @(negedge clock);
        verif("desiste_estado", db_estado, 4'b0000);
        verif("desiste_partida", tx_partida, 1'b0);
        verif("desiste_dados", tx_dados, last_d);
        verif("desiste_vez", db_vez, last_w);
        @(posedge clock);
        #1;

        aleatorio = 1'b1;
        repeat (40) begin
            pedido = pedido | N'($urandom);
            if (pedido == 0) pedido[$urandom_range(0, N - 1)] = 1'b1;
            transacao(sorteia_d(), -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/arbitro_saida_serial.md
Name: arbitro_saida_serial

Overview:
- Sequencer and round-robin arbiter that shares one serial transmitter among N requesters.
- Picks one pending requester and latches its data word onto the transmitter's data input.
- Pulses the transmitter start (partida), then waits for its pronto and acknowledges the winner.
- A watchdog aborts a transmission whose pronto never arrives. Sits between the application blocks and the serial output unit.

Parameters:
- N, 4, number of requesters (2..8).
- W, 7, data word width per requester.
- TIMEOUT, 4096, max cycles spent in AGUARDA before abort (>=2).

Ports:
- clock  in  1  system clock, all state changes on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clock edge).
- pedido  in  N  level request per requester; held until its concedido pulse.
- dados  in  N*W  requester i data on bits [i*W+W-1 : i*W].
- tx_pronto  in  1  transmitter finished pulse (>=1 cycle).
- tx_partida  out  1  one-cycle start pulse to the transmitter.
- tx_dados  out  W  registered data word to the transmitter.
- concedido  out  N  one-hot, one-cycle ack to the served requester.
- erro  out  1  one-cycle pulse on watchdog abort.
- ocupado  out  1  high in every state except OCIOSO.
- db_vez  out  3  index of current/last winner (zero-extended).
- db_estado  out  4  state code for debug display.

Behaviour:
- Reset (reset==0 at an edge): state=OCIOSO, round-robin pointer=0, watchdog=0, tx_dados=0, db_vez=0. All pulse outputs 0. Reset applies from any state and aborts a transmission in progress without concedido or erro.
- Moore FSM; db_estado codes:
  - OCIOSO 0000: any pedido -> ARBITRA, else stay.
  - ARBITRA 0001: winner = first i with pedido[i]=1, searching ptr, ptr+1, ... mod N. Latch idx and dados slice into tx_dados, clear watchdog -> CARREGA. If pedido has dropped to all zero -> OCIOSO, with no latch.
  - CARREGA 0011: tx_partida=1 -> AGUARDA. tx_pronto is ignored here.
  - AGUARDA 0111: tx_pronto=1 -> CONCLUI. Otherwise the watchdog increments; when watchdog==TIMEOUT-1 -> ERRO. tx_pronto wins if both occur in the same cycle.
  - CONCLUI 1111: concedido[idx]=1; ptr <= (idx+1) mod N -> OCIOSO.
  - ERRO 1110: erro=1; ptr <= (idx+1) mod N, so a dead requester cannot starve others -> OCIOSO.
  - Illegal state codes: db_estado=1101, next state OCIOSO.
- Latency: pedido seen in OCIOSO at edge k -> tx_partida high during cycle k+2. concedido is high in the cycle after the edge that samples tx_pronto in AGUARDA.
- Minimum turnaround: 5 cycles per served request (OCIOSO, ARBITRA, CARREGA, AGUARDA>=1, CONCLUI).
- tx_dados holds its value from ARBITRA exit until the next latch.
- Changes to dados or pedido after latch do not affect the transfer in progress. Dropping pedido mid-transfer still yields concedido.
- Watchdog width is clog2(TIMEOUT); it counts only in AGUARDA. Aborted requester's pedido stays pending and is retried in its next round-robin turn.
- db_vez = idx register (updated in ARBITRA).

Test Plan:
1. N=4, W=7, only pedido[2]=1 with dados slice 7'h41; tx_pronto 10 cycles after partida. Required: tx_dados=7'h41, a single tx_partida pulse, concedido=4'b0100 one cycle, db_vez=2, ptr=3, back to OCIOSO (0000).
2. pedido=4'b1111 held continuously, each served then dropped. Required: grant order 0,1,2,3 with concedido pulses 0001, 0010, 0100, 1000 and exactly one partida per grant.
3. ptr=3 after scenario 1, pedido=4'b0101. Required: requester 0 granted first (wrap-around), then requester 2.
4. TIMEOUT=8, tx_pronto never asserted. Required: exactly 8 cycles in AGUARDA, then ERRO (1110) with erro pulse, no concedido, and ptr advances past the aborted requester.
5. tx_pronto asserted on the same cycle watchdog==TIMEOUT-1. Required: CONCLUI taken, concedido pulses, erro stays 0.
6. reset=0 for one edge while in AGUARDA. Required: next cycle OCIOSO, all outputs 0, ptr=0, no concedido or erro. After reset=1 with pedido still high, a normal arbitration restarts.
